shift_seq: RTL



---
 rtl/shift_seq.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/shift_seq.sv
// shift_seq: control stage feeding a cascaded mc10141 shift-register chain.
// Sequences an optional parallel load followed by N single-bit shifts with
// zero / one / arithmetic / rotate fill. It also runs a start/busy/done
// handshake toward the requesting microcode logic.
//
// Chain orientation: q[0] of the first part is the word MSB and q[3] of the
// last part is the word LSB. SHIFTR moves data toward q[0], so new bits enter
// at d3In of the last part. SHIFTL moves data toward q[3], so new bits enter
// at d0In of the first part.
module shift_seq #(
    parameter int CNTW = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            ld,
    input  logic            dir,
    input  logic [1:0]      fill,
    input  logic [CNTW-1:0] count,
    input  logic            qFirst,
    input  logic            qLast,
    output logic [1:0]      mode,
    output logic            d0In,
    output logic            d3In,
    output logic            busy,
    output logic            done,
    output logic [CNTW-1:0] remain
);

    // Sequencer states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // tMode141 encoding shared by every part of the chain
    typedef enum logic [1:0] {
        M_LOAD   = 2'd0,
        M_SHIFTL = 2'd1,
        M_SHIFTR = 2'd2,
        M_HOLD   = 2'd3
    } mode_t;

    // Fill selector encoding
    typedef enum logic [1:0] {
        F_ZERO  = 2'd0,
        F_ONE   = 2'd1,
        F_ARITH = 2'd2,
        F_ROT   = 2'd3
    } fill_t;

    state_t          r_state;
    state_t          w_stateNext;
    logic [CNTW-1:0] r_remain;
    logic [CNTW-1:0] w_remainNext;
    logic            r_dir;
    logic [1:0]      r_fill;
    logic            w_accept;
    logic            w_fillBit;
    mode_t           w_mode;

    // A request is only taken while idle; busy and done states ignore start
    assign w_accept = (r_state == S_IDLE) && start;

    // State, remaining count and the request parameters latched at acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_remain <= '0;
            r_dir    <= 1'b0;
            r_fill   <= 2'b00;
        end else begin
            r_state  <= w_stateNext;
            r_remain <= w_remainNext;
            if (w_accept) begin
                r_dir  <= dir;
                r_fill <= fill;
            end
        end
    end

    // Next-state and next remaining-count logic
    always_comb begin
        w_stateNext  = r_state;
        w_remainNext = r_remain;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_remainNext = count;
                    if (ld) begin
                        w_stateNext = S_LOAD;
                    end else if (count != '0) begin
                        w_stateNext = S_SHIFT;
                    end else begin
                        w_stateNext = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                if (r_remain != '0) begin
                    w_stateNext = S_SHIFT;
                end else begin
                    w_stateNext = S_DONE;
                end
            end
            S_SHIFT: begin
                // remain is never zero here; the guard keeps it from wrapping below zero
                if (r_remain != '0) begin
                    w_remainNext = r_remain - CNTW'(1);
                end
                if (r_remain <= CNTW'(1)) begin
                    w_stateNext = S_DONE;
                end
            end
            S_DONE: begin
                w_stateNext = S_IDLE;
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // Chain mode, handshake outputs decoded from the current state
    always_comb begin
        w_mode = M_HOLD;
        busy   = 1'b0;
        done   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_mode = M_HOLD;
            end
            S_LOAD: begin
                w_mode = M_LOAD;
                busy   = 1'b1;
            end
            S_SHIFT: begin
                w_mode = r_dir ? M_SHIFTL : M_SHIFTR;
                busy   = 1'b1;
            end
            S_DONE: begin
                w_mode = M_HOLD;
                done   = 1'b1;
            end
            default: begin
                w_mode = M_HOLD;
            end
        endcase
    end

    // Serial fill bit from live chain ends so rotate/arithmetic see pre-edge data
    always_comb begin
        w_fillBit = 1'b0;
        unique case (fill_t'(r_fill))
            F_ZERO:  w_fillBit = 1'b0;
            F_ONE:   w_fillBit = 1'b1;
            F_ARITH: w_fillBit = r_dir ? qFirst : 1'b0;
            F_ROT:   w_fillBit = r_dir ? qLast : qFirst;
            default: w_fillBit = 1'b0;
        endcase
    end

    // Route the fill bit to the entering end only while shifting
    always_comb begin
        d0In = 1'b0;
        d3In = 1'b0;
        if (r_state == S_SHIFT) begin
            if (r_dir) begin
                d0In = w_fillBit;
            end else begin
                d3In = w_fillBit;
            end
        end
    end

    assign mode   = w_mode;
    assign remain = r_remain;

endmodule
